// File: rtl/rr_sched_pkg.sv
// Shared types and default sizing for the round-robin decoder arbiter.
package rr_sched_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam int DEF_IDX_W    = 3;
  localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/decoder_nbit.sv
// N-bit binary to one-hot decoder with enable; all-zero output when disabled.
module decoder_nbit #(
  parameter int N = 3
) (
  input  logic [N-1:0]    a,
  input  logic            enable,
  output logic [2**N-1:0] y
);

  always_comb begin
    y = '0;
    if (enable) y[a] = 1'b1;
  end

endmodule

// File: rtl/rr_pick_next.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick_next
  import rr_sched_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [2**IDX_W-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [IDX_W-1:0]    pick,
  output logic                any_req
);

  localparam int NREQ = 2**IDX_W;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  off;

  // Rotating the doubled vector puts requester ptr at bit 0, so the lowest set
  // bit of rot is the round-robin offset; adding it back to ptr wraps for free.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    pick    = ptr + off;
    any_req = |req;
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter with hold limit and one-cycle turnaround between grants;
// the one-hot grant is decoded purely from registered state.
module rr_decoder_arbiter
  import rr_sched_pkg::*;
#(
  parameter int IDX_W    = DEF_IDX_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2**IDX_W-1:0] req,
  input  logic                done,
  output logic [2**IDX_W-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid,
  output logic                timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [IDX_W-1:0] ptr_q, ptr_nxt;
  logic [HW-1:0]    hold_q, hold_nxt;
  logic             valid_q, valid_nxt;
  logic             timeout_q, timeout_nxt;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             at_limit;
  logic             rel;

  rr_pick_next #(.IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .any_req (any_req)
  );

  assign at_limit = (hold_q == HW'(MAX_HOLD - 1));
  assign rel      = done | ~req[idx_q] | at_limit;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx_q;
    ptr_nxt     = ptr_q;
    hold_nxt    = hold_q;
    valid_nxt   = valid_q;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          idx_nxt   = pick;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (rel) begin
          valid_nxt   = 1'b0;
          ptr_nxt     = idx_q + IDX_W'(1);
          // Only a pure hold-limit revocation is flagged; a voluntary release wins.
          timeout_nxt = at_limit & ~done & req[idx_q];
          state_nxt   = IDLE;
        end else begin
          hold_nxt = hold_q + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx_q     <= idx_nxt;
      ptr_q     <= ptr_nxt;
      hold_q    <= hold_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  decoder_nbit #(.N(IDX_W)) u_dec (
    .a      (idx_q),
    .enable (valid_q),
    .y      (grant)
  );

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_rr_decoder_arbiter;

  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 4;
  localparam int NREQ     = 2**IDX_W;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic            grant_valid;
  logic            timeout;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: who holds the grant (-1 = nobody), how many cycles the
  // current grant has been visible, the next scan start and last holder.
  int m_holder = -1;
  int m_last = 0;
  int m_ptr = 0;
  int m_held = 0;
  bit m_to = 1'b0;
  bit m_ready = 1'b0;

  rr_decoder_arbiter #(.IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    int nxt;
    nxt = -1;
    if (!rst_n) begin
      m_holder <= -1;
      m_last   <= 0;
      m_ptr    <= 0;
      m_held   <= 0;
      m_to     <= 1'b0;
      m_ready  <= 1'b1;
    end else if (m_holder < 0) begin
      m_to <= 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req[(m_ptr + k) % NREQ]) nxt = (m_ptr + k) % NREQ;
      end
      if (nxt >= 0) begin
        m_holder <= nxt;
        m_last   <= nxt;
        m_held   <= 1;
      end
    end else if (done || !req[m_holder] || m_held == MAX_HOLD) begin
      m_to     <= (m_held == MAX_HOLD) && !done && req[m_holder];
      m_ptr    <= (m_holder + 1) % NREQ;
      m_holder <= -1;
    end else begin
      m_held <= m_held + 1;
      m_to   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0]  exp_g;
    logic [IDX_W-1:0] exp_i;
    logic             exp_v;
    if (m_ready) begin
      exp_g = (m_holder >= 0) ? (NREQ'(1) << m_holder) : '0;
      exp_i = IDX_W'(m_last);
      exp_v = (m_holder >= 0);
      tests_run++;
      if (grant !== exp_g || grant_idx !== exp_i || grant_valid !== exp_v || timeout !== m_to) begin
        tests_failed++;
        $display("[TB] FAIL model t=%0t: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                 $time, grant, grant_idx, grant_valid, timeout, exp_g, exp_i, exp_v, m_to);
      end
    end
  end

  // Drive inputs at a falling edge, then step to the next falling edge so the
  // effect of the intervening rising edge is visible.
  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [NREQ-1:0] g,
                             input logic [IDX_W-1:0] i, input logic v, input logic t);
    tests_run++;
    if (grant !== g || grant_idx !== i || grant_valid !== v || timeout !== t) begin
      tests_failed++;
      $display("[TB] FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
               name, grant, grant_idx, grant_valid, timeout, g, i, v, t);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    @(negedge clk);

    // Reset dominates even with every requester active.
    applyStimulus(8'hFF, 1'b0);
    checkOutput("reset_a", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("reset_b", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single requester, released by done; pointer then wraps past 7.
    applyStimulus(8'h10, 1'b0);
    checkOutput("grant4", 8'h10, 3'd4, 1'b1, 1'b0);
    applyStimulus(8'h10, 1'b0);
    checkOutput("hold4", 8'h10, 3'd4, 1'b1, 1'b0);
    applyStimulus(8'h10, 1'b1);
    checkOutput("done4", 8'h00, 3'd4, 1'b0, 1'b0);
    applyStimulus(8'h11, 1'b0);
    checkOutput("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);

    // All requesting: strict rotation with a bubble between grants.
    applyStimulus(8'hFF, 1'b1);
    checkOutput("rel0", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 1; k <= NREQ; k++) begin
      applyStimulus(8'hFF, 1'b0);
      checkOutput("rr_grant", NREQ'(1) << (k % NREQ), IDX_W'(k % NREQ), 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1);
      checkOutput("rr_gap", 8'h00, IDX_W'(k % NREQ), 1'b0, 1'b0);
    end

    // Hold limit: four granted cycles, timeout bubble, then regrant.
    for (int k = 0; k < MAX_HOLD; k++) begin
      applyStimulus(8'h01, 1'b0);
      checkOutput("hold_lim", 8'h01, 3'd0, 1'b1, 1'b0);
    end
    applyStimulus(8'h01, 1'b0);
    checkOutput("timeout", 8'h00, 3'd0, 1'b0, 1'b1);
    applyStimulus(8'h01, 1'b0);
    checkOutput("regrant0", 8'h01, 3'd0, 1'b1, 1'b0);

    // Requester drop releases without timeout; done on the limit cycle wins.
    applyStimulus(8'h00, 1'b0);
    checkOutput("drop0", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(8'h06, 1'b0);
    checkOutput("grant1", 8'h02, 3'd1, 1'b1, 1'b0);
    applyStimulus(8'h04, 1'b0);
    checkOutput("drop1", 8'h00, 3'd1, 1'b0, 1'b0);
    applyStimulus(8'h04, 1'b0);
    checkOutput("grant2", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int k = 1; k < MAX_HOLD; k++) applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h04, 1'b1);
    checkOutput("done_at_limit", 8'h00, 3'd2, 1'b0, 1'b0);

    // Reset mid-grant clears grant and pointer.
    applyStimulus(8'h20, 1'b0);
    checkOutput("grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    rst_n = 1'b0;
    applyStimulus(8'hFF, 1'b0);
    checkOutput("reset_busy", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 1'b0);
    checkOutput("after_reset", 8'h01, 3'd0, 1'b1, 1'b0);

    // Randomized traffic: requests mostly stable, occasional done and reset.
    for (int n = 0; n < 3000; n++) begin
      logic [NREQ-1:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = NREQ'($urandom & $urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus(r, $urandom_range(0, 5) == 0);
    end
    rst_n = 1'b1;
    applyStimulus(8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
